// File: rtl/psg_i2s_out.sv
// PSG mix to Philips I2S: decimate to one mono sample per frame, convert to two's complement, send it on both channels.
// Latency: a sample decimated over frame k is sent in frame k+1, MSB on sdata the clock after the frame boundary.
// No backpressure: sampleIn is taken every clock. Define PSG_I2S_AVG_EN to average the frame instead of holding one sample.
module psg_i2s_out #(
   parameter int BCLK_HALF_LOG2 = 0
) (
   input  logic        clock,
   input  logic        nReset,
   input  logic [15:0] sampleIn,
   input  logic        mute,
   output logic        bclk,
   output logic        lrclk,
   output logic        sdata,
   output logic        frameStrobe
);

   localparam int PW = 6 + BCLK_HALF_LOG2;

   logic [PW-1:0] phase;
   logic [PW-1:0] phase_nxt;
   logic [4:0]    slot_nxt;
   logic          slot_start;
   logic          boundary;
   logic [15:0]   sample_s;
   logic [15:0]   word;
   logic [31:0]   shift_reg;

   assign phase_nxt  = phase + 1'b1;
   assign slot_nxt   = phase_nxt[PW-1:BCLK_HALF_LOG2+1];
   assign slot_start = (phase_nxt[BCLK_HALF_LOG2:0] == '0);
   assign boundary   = &phase;

`ifdef PSG_I2S_AVG_EN
   // Sized so a full frame of 16'hFFFF cannot overflow.
   logic [15+PW:0] acc;

   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         acc <= '0;
      end else if (boundary) begin
         acc <= {{PW{1'b0}}, sampleIn};
      end else begin
         acc <= acc + {{PW{1'b0}}, sampleIn};
      end
   end

   assign sample_s = 16'(acc >> PW);
`else
   assign sample_s = sampleIn;
`endif

   assign word = mute ? 16'h0000 : {~sample_s[15], sample_s[14:0]};

   // lrclk leads the data by one slot: it drops for slot 31 ahead of the left MSB.
   always_ff @(posedge clock or negedge nReset) begin
      if (!nReset) begin
         phase       <= '0;
         bclk        <= 1'b0;
         lrclk       <= 1'b0;
         sdata       <= 1'b0;
         frameStrobe <= 1'b0;
         shift_reg   <= '0;
      end else begin
         phase       <= phase_nxt;
         bclk        <= phase_nxt[BCLK_HALF_LOG2];
         frameStrobe <= boundary;
         if (slot_start) begin
            lrclk <= (slot_nxt >= 5'd15) && (slot_nxt != 5'd31);
            sdata <= boundary ? word[15] : shift_reg[5'd31 - slot_nxt];
         end
         if (boundary) begin
            shift_reg <= {word, word};
         end
      end
   end

endmodule
